// File: rtl/fm_demod_gated.sv
// fm_demod_gated: delay-and-multiply FM discriminator with boxcar lowpass,
// saturation, hold-extended range gating and blank-interval/peak measurement.
module fm_demod_gated #(
  parameter int DATA_W   = 12,
  parameter int OUT_W    = 10,
  parameter int DELAY    = 6,
  parameter int AVG_LOG2 = 3,
  parameter int SHIFT    = 14,
  parameter int HOLD_CYC = 400,
  parameter int CNT_W    = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [OUT_W-1:0]  thr_lo,
  input  logic signed [OUT_W-1:0]  thr_hi,
  input  logic signed [OUT_W-1:0]  blank_value,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic signed [OUT_W-1:0]  demod_raw,
  output logic                     overrange,
  output logic [CNT_W-1:0]         interval,
  output logic                     interval_valid,
  output logic signed [OUT_W-1:0]  peak_value,
  output logic                     peak_valid
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + AVG_LOG2;
  localparam int N  = 1 << AVG_LOG2;
  localparam int HW = $clog2(HOLD_CYC + 2);
  localparam logic signed [SW-1:0] SMAX = SW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [SW-1:0] SMIN = ~SMAX;
  typedef enum logic [1:0] {IDLE, MEAS, PEAK} state_t;
  state_t state, state_n;
  logic [DELAY-1:0][DATA_W-1:0] line;
  logic [N-1:0][PW-1:0] pline;
  logic signed [PW-1:0] p;
  logic signed [SW-1:0] sum, sh;
  logic signed [OUT_W-1:0] s, mx, mx_n;
  logic [HW-1:0] hold;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic v1, v2, oor, ovr, iv, pv;
  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
      p <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        p <= in_data * $signed(line[DELAY-1]);
        line[0] <= in_data;
        for (int i = 1; i < DELAY; i++) line[i] <= line[i-1];
      end
    end
  end
  // running boxcar: add the newest product, drop the one leaving the window
  always_ff @(posedge clk) begin
    if (rst) begin
      pline <= '0;
      sum <= '0;
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sum <= sum + SW'(p) - SW'($signed(pline[N-1]));
        pline[0] <= p;
        for (int i = 1; i < N; i++) pline[i] <= pline[i-1];
      end
    end
  end
  assign sh  = sum >>> SHIFT;
  assign s   = sh > SMAX ? SMAX[OUT_W-1:0] : sh < SMIN ? SMIN[OUT_W-1:0] : sh[OUT_W-1:0];
  assign oor = (s < thr_lo) || (s > thr_hi);
  assign ovr = oor || (hold != '0);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mx_n = mx;
    iv = 1'b0;
    pv = 1'b0;
    if (v2)
      case (state)
        IDLE: if (ovr) begin
          cnt_n = CNT_W'(1);
          state_n = MEAS;
        end
        MEAS: if (ovr) cnt_n = &cnt ? cnt : cnt + CNT_W'(1);
        else begin
          iv = 1'b1;
          mx_n = s;
          state_n = PEAK;
        end
        PEAK: if (ovr) begin
          pv = 1'b1;
          cnt_n = CNT_W'(1);
          state_n = MEAS;
        end else mx_n = s > mx ? s : mx;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      demod_raw <= '0;
      overrange <= 1'b0;
      interval <= '0;
      interval_valid <= 1'b0;
      peak_value <= '0;
      peak_valid <= 1'b0;
      hold <= '0;
      cnt <= '0;
      mx <= '0;
    end else begin
      out_valid <= v2;
      interval_valid <= iv;
      peak_valid <= pv;
      cnt <= cnt_n;
      mx <= mx_n;
      if (iv) interval <= cnt;
      if (pv) peak_value <= mx;
      if (v2) begin
        demod_raw <= s;
        overrange <= ovr;
        out_data <= ovr ? blank_value : s;
        hold <= oor ? HW'(HOLD_CYC) : (hold != '0 ? hold - HW'(1) : hold);
      end
    end
  end
endmodule

// File: tb/tb_fm_demod_gated.sv
// tb_fm_demod_gated: random and directed stimulus on two instances (default
// and short-counter/no-hold) checked against an arithmetic reference model.
module tb_fm_demod_gated;
  localparam int DL = 6;
  localparam int NB = 8;
  localparam int SH = 14;
  localparam int H0 = 400;
  localparam int C0 = 14;
  localparam int H1 = 0;
  localparam int C1 = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [11:0] in_data = '0;
  logic signed [9:0] thr_lo = '0, thr_hi = '0, blank_value = '0;
  logic ov [2], oc [2], ivl [2], pvl [2];
  logic signed [9:0] od [2], dr [2], pk [2];
  logic [C0-1:0] iv0;
  logic [C1-1:0] iv1;
  fm_demod_gated #(.HOLD_CYC(H0), .CNT_W(C0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .blank_value(blank_value),
    .out_valid(ov[0]), .out_data(od[0]), .demod_raw(dr[0]), .overrange(oc[0]),
    .interval(iv0), .interval_valid(ivl[0]), .peak_value(pk[0]), .peak_valid(pvl[0])
  );
  fm_demod_gated #(.HOLD_CYC(H1), .CNT_W(C1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .blank_value(blank_value),
    .out_valid(ov[1]), .out_data(od[1]), .demod_raw(dr[1]), .overrange(oc[1]),
    .interval(iv1), .interval_valid(ivl[1]), .peak_value(pk[1]), .peak_valid(pvl[1])
  );
  always #5 clk = ~clk;
  typedef struct {longint s; int due;} item_t;
  item_t q[$];
  longint hist[$], prods[$];
  int step_no = 0;
  int checks = 0, errors = 0;
  int mhold [2], mcnt [2];
  bit meas [2], win [2];
  longint mx [2], e_od [2], e_dr [2], e_int [2], e_pk [2];
  bit e_ovr [2];
  longint last_int0 = -1, last_int1 = -1, last_pk0 = -1;
  int nblank = 0;
  task automatic chk(string tag, logic signed [63:0] got, logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0d expected %0d", tag, step_no, got, exp);
    end
  endtask
  task automatic model_reset();
    hist.delete();
    prods.delete();
    q.delete();
    for (int i = 0; i < 2; i++) begin
      mhold[i] = 0; mcnt[i] = 0; meas[i] = 0; win[i] = 0; mx[i] = 0;
      e_od[i] = 0; e_dr[i] = 0; e_int[i] = 0; e_pk[i] = 0; e_ovr[i] = 0;
    end
  endtask
  task automatic push_sample(logic signed [11:0] x);
    longint prev, sum, s;
    prev = hist.size() >= DL ? hist[hist.size() - DL] : 0;
    hist.push_back(longint'(x));
    if (hist.size() > DL) void'(hist.pop_front());
    prods.push_back(longint'(x) * prev);
    if (prods.size() > NB) void'(prods.pop_front());
    sum = 0;
    foreach (prods[k]) sum += prods[k];
    s = sum >>> SH;
    s = s > 511 ? 511 : s < -512 ? -512 : s;
    q.push_back('{s, step_no + 3});
  endtask
  task automatic do_check();
    bit due, ivs, pvs, oor;
    longint s;
    int hc, cm;
    due = q.size() > 0 && q[0].due == step_no;
    s = due ? q[0].s : 0;
    for (int i = 0; i < 2; i++) begin
      ivs = 0;
      pvs = 0;
      hc = i ? H1 : H0;
      cm = i ? (1 << C1) - 1 : (1 << C0) - 1;
      if (due) begin
        oor = s < thr_lo || s > thr_hi;
        if (oor) begin e_ovr[i] = 1; mhold[i] = hc; end
        else if (mhold[i] > 0) begin e_ovr[i] = 1; mhold[i]--; end
        else e_ovr[i] = 0;
        e_dr[i] = s;
        e_od[i] = e_ovr[i] ? longint'(blank_value) : s;
        if (e_ovr[i]) begin
          if (meas[i]) mcnt[i] = mcnt[i] < cm ? mcnt[i] + 1 : cm;
          else begin
            if (win[i]) begin e_pk[i] = mx[i]; pvs = 1; end
            meas[i] = 1; win[i] = 0; mcnt[i] = 1;
          end
        end else if (meas[i]) begin
          e_int[i] = mcnt[i]; ivs = 1; meas[i] = 0; win[i] = 1; mx[i] = s;
        end else if (win[i] && s > mx[i]) mx[i] = s;
      end
      chk($sformatf("out_valid%0d", i), ov[i], due);
      chk($sformatf("out_data%0d", i), od[i], e_od[i]);
      chk($sformatf("demod_raw%0d", i), dr[i], e_dr[i]);
      chk($sformatf("overrange%0d", i), oc[i], e_ovr[i]);
      chk($sformatf("interval%0d", i), i ? iv1 : iv0, e_int[i]);
      chk($sformatf("interval_valid%0d", i), ivl[i], ivs);
      chk($sformatf("peak_value%0d", i), pk[i], e_pk[i]);
      chk($sformatf("peak_valid%0d", i), pvl[i], pvs);
    end
    if (due) void'(q.pop_front());
    if (ivl[0]) last_int0 = iv0;
    if (ivl[1]) last_int1 = iv1;
    if (pvl[0]) last_pk0 = pk[0];
    if (ov[0] && oc[0]) nblank++;
  endtask
  task automatic step(bit v, logic signed [11:0] x);
    @(negedge clk);
    do_check();
    in_valid = v;
    in_data = x;
    if (v && !rst) push_sample(x);
    step_no++;
  endtask
  task automatic do_reset(int n);
    rst = 1'b1;
    model_reset();
    repeat (n) step(1'b0, '0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_data", od[i], 0);
      chk("rst_demod_raw", dr[i], 0);
      chk("rst_overrange", oc[i], 0);
      chk("rst_peak_value", pk[i], 0);
    end
    chk("rst_interval", iv0, 0);
  endtask
  initial begin
    thr_lo = -300;
    thr_hi = 450;
    blank_value = 200;
    do_reset(2);
    repeat (40) step(1'b1, 724);
    chk("dc_demod_raw", dr[0], 255);
    chk("dc_out_data", od[0], 255);
    chk("dc_overrange", oc[0], 0);
    repeat (300) begin
      if ($urandom_range(0, 15) == 0) begin
        thr_lo = 10'(int'($urandom_range(0, 700)) - 400);
        thr_hi = 10'(int'($urandom_range(0, 700)) - 300);
        blank_value = 10'($urandom);
      end
      step($urandom_range(0, 3) != 0, 12'($urandom));
    end
    do_reset(2);
    thr_lo = -300;
    thr_hi = 450;
    blank_value = 200;
    step(1'b1, 100);
    step(1'b0, 0);
    step(1'b0, 0);
    chk("lat_early", ov[0], 0);
    step(1'b0, 0);
    chk("lat_first", ov[0], 1);
    repeat (200) step($urandom_range(0, 2) != 0, 12'($urandom));
    repeat (40) step(1'b1, -2048);
    chk("sat_demod_raw", dr[0], 511);
    chk("sat_out_data", od[0], 200);
    chk("sat_overrange", oc[0], 1);
    chk("sat_no_strobe", ivl[0], 0);
    repeat (900) step(step_no % 2 == 0, 724);
    thr_hi = 200;
    nblank = 0;
    last_int0 = -1;
    last_int1 = -1;
    repeat (2) step(step_no % 2 == 0, 724);
    thr_hi = 450;
    repeat (900) step(step_no % 2 == 0, 724);
    chk("hold_blanked", nblank, 401);
    chk("hold_interval", last_int0, 401);
    chk("nohold_interval", last_int1, 1);
    chk("hold_released", oc[0], 0);
    last_pk0 = -1;
    repeat (40) step(1'b1, 453);
    chk("peak_seg100", dr[0], 100);
    repeat (40) step(1'b1, 724);
    repeat (40) step(1'b1, -600);
    chk("peak_seg175", dr[0], 175);
    thr_hi = 50;
    step(1'b1, -600);
    thr_hi = 450;
    repeat (6) step(1'b1, -600);
    chk("peak_value", last_pk0, 255);
    repeat (60) step(1'b1, 724);
    last_int1 = -1;
    thr_hi = 200;
    repeat (20) step(1'b1, 724);
    thr_hi = 450;
    repeat (10) step(1'b1, 724);
    chk("cnt_saturate", last_int1, 15);
    repeat (10) step(1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
